// File: rtl/stm_audio_tx_if.sv
// rtl/stm_audio_tx_if.sv - Audio_Controller pop port and STM32 GPIO handshake bundle
interface stm_audio_tx_if #(
    parameter int AW = 16
);
    logic          audio_in_available;
    logic [AW-1:0] left_channel_audio_in;
    logic [AW-1:0] right_channel_audio_in;
    logic          read_audio_in;
    logic [AW-1:0] stm_data;
    logic          stm_valid;
    logic          stm_ack;

    modport master (
        input  audio_in_available, left_channel_audio_in, right_channel_audio_in, stm_ack,
        output read_audio_in, stm_data, stm_valid
    );

    modport slave (
        output audio_in_available, left_channel_audio_in, right_channel_audio_in, stm_ack,
        input  read_audio_in, stm_data, stm_valid
    );
endinterface

// File: rtl/stm_audio_tx.sv
// rtl/stm_audio_tx.sv - ADC drain, mono FIFO and 4-phase GPIO sender to STM32
// Optional STM_TX_TESTPAT_EN replaces audio with a push-advanced counter for link bring-up.
module stm_audio_tx #(
    parameter int AUDIO_WIDTH = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int CHANNEL_SEL = 2,
    parameter int ACK_TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    stm_audio_tx_if.master              bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    output logic                        ack_timeout
);
    localparam int AW = AUDIO_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = (ACK_TIMEOUT > 0) ? TW'(ACK_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, PRESENT, RELEASE} state_t;

    state_t        state, next_state;
    logic          read_q;
    logic          capture;
    logic [AW:0]   sum;
    logic [AW-1:0] mono;
    logic [AW-1:0] cap_word;
    logic [AW-1:0] push_word;
    logic [AW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;
    logic          ack_m, ack_s;
    logic [TW-1:0] timer;
    logic          expired;
    logic          set_timeout;
    logic          stm_valid_q;
    logic [AW-1:0] stm_data_q;

    always_comb begin
        sum = {bus.left_channel_audio_in[AW-1], bus.left_channel_audio_in}
            + {bus.right_channel_audio_in[AW-1], bus.right_channel_audio_in};
        case (CHANNEL_SEL)
            0:       mono = bus.left_channel_audio_in;
            1:       mono = bus.right_channel_audio_in;
            default: mono = AW'(sum >> 1);
        endcase
    end

    // The pop strobe doubles as the push-attempt strobe one edge after the pair is taken.
    assign capture = bus.audio_in_available && !read_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_q   <= 1'b0;
            cap_word <= '0;
        end else begin
            read_q <= capture;
            if (capture) cap_word <= mono;
        end
    end

    assign bus.read_audio_in = read_q;

`ifdef STM_TX_TESTPAT_EN
    logic [AW-1:0] pat_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     pat_cnt <= '0;
        else if (push) pat_cnt <= pat_cnt + 1'b1;
    end
    assign push_word = pat_cnt;
`else
    assign push_word = cap_word;
`endif

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign push  = read_q && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (read_q && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_word;
    end

    assign fifo_level = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_m <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_m <= bus.stm_ack;
            ack_s <= ack_m;
        end
    end

    assign expired = (ACK_TIMEOUT != 0) && (timer == TLAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!empty)           next_state = PRESENT;
            PRESENT: if (ack_s || expired) next_state = RELEASE;
            RELEASE: if (!ack_s || expired) next_state = IDLE;
            default:                       next_state = IDLE;
        endcase
    end

    // An ack seen on the expiring cycle still counts as a clean handshake.
    always_comb begin
        pop         = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE:    pop         = !empty;
            PRESENT: set_timeout = !ack_s && expired;
            RELEASE: set_timeout = ack_s && expired;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            stm_valid_q <= 1'b0;
            stm_data_q  <= '0;
            ack_timeout <= 1'b0;
        end else begin
            timer       <= (next_state != state) ? '0 : timer + 1'b1;
            stm_valid_q <= (next_state == PRESENT);
            if (pop)         stm_data_q  <= mem[rd_ptr];
            if (set_timeout) ack_timeout <= 1'b1;
        end
    end

    assign bus.stm_valid = stm_valid_q;
    assign bus.stm_data  = stm_data_q;
endmodule

// File: tb/tb_stm_audio_tx.sv
// tb/tb_stm_audio_tx.sv - randomized bench for stm_audio_tx against a queue-based sample model
`timescale 1ns/1ps
module tb_stm_audio_tx;
    localparam int AW    = 16;
    localparam int DEPTH = 8;
    localparam int CSEL  = 2;
    localparam int TMO   = 100;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [$clog2(DEPTH):0]   fifo_level;
    logic                     overflow;
    logic                     ack_timeout;

    int checks   = 0;
    int failures = 0;
    int read_cnt = 0;
    int dbl_read = 0;
    logic read_prev = 1'b0;

    logic [AW-1:0] exp_q[$];
    int            pat_next = 0;

    stm_audio_tx_if #(.AW(AW)) bus();

    stm_audio_tx #(
        .AUDIO_WIDTH(AW),
        .FIFO_DEPTH (DEPTH),
        .CHANNEL_SEL(CSEL),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .ack_timeout(ack_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.read_audio_in) read_cnt++;
        if (bus.read_audio_in && read_prev) dbl_read++;
        read_prev = bus.read_audio_in;
    end

    initial begin
        #500us;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [AW-1:0] mono_of(input logic [AW-1:0] l, input logic [AW-1:0] r);
        int s;
        if (CSEL == 0) return l;
        if (CSEL == 1) return r;
        s = int'($signed(l)) + int'($signed(r));
        return AW'(s >>> 1);
    endfunction

    // One word can sit on stm_data while DEPTH more wait, as long as the STM32 is not acking.
    function automatic void model_capture(input logic [AW-1:0] l, input logic [AW-1:0] r);
        if (exp_q.size() < DEPTH + 1) begin
`ifdef STM_TX_TESTPAT_EN
            exp_q.push_back(AW'(pat_next));
`else
            exp_q.push_back(mono_of(l, r));
`endif
            pat_next++;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pat_next = 0;
    endfunction

    task automatic send_sample(input logic [AW-1:0] l, input logic [AW-1:0] r, output bit got);
        got = 1'b0;
        bus.left_channel_audio_in  = l;
        bus.right_channel_audio_in = r;
        bus.audio_in_available     = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = bus.read_audio_in;
        end
        bus.audio_in_available = 1'b0;
        if (got) model_capture(l, r);
    endtask

    task automatic wait_valid(input logic level, input int max, output int n);
        n = 0;
        while (bus.stm_valid !== level && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake(output logic [AW-1:0] data, output bit seen, output int fall_edges);
        int n;
        fall_edges = -1;
        wait_valid(1'b1, 50, n);
        seen = (bus.stm_valid === 1'b1);
        data = bus.stm_data;
        if (seen) begin
            bus.stm_ack = 1'b1;
            wait_valid(1'b0, 20, fall_edges);
            bus.stm_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.audio_in_available = 1'b0;
        bus.left_channel_audio_in = '0;
        bus.right_channel_audio_in = '0;
        bus.stm_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.read_audio_in !== 1'b0) begin failures++; $display("FAIL reset_read got=%b want=0", bus.read_audio_in); end
        checks++; if (bus.stm_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.stm_valid); end
        checks++; if (bus.stm_data !== '0) begin failures++; $display("FAIL reset_data got=%h want=0", bus.stm_data); end
        checks++; if (fifo_level !== '0) begin failures++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (ack_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b want=0", ack_timeout); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_latency();
        bit got, seen;
        int r0, fe;
        logic [AW-1:0] d;
        r0 = read_cnt;
        send_sample(16'h1234, 16'h0010, got);
        checks++; if (!got) begin failures++; $display("FAIL lat_read got=none want=pulse"); end
        @(negedge clk);
        checks++; if (bus.stm_valid !== 1'b0) begin failures++; $display("FAIL lat_valid_early got=%b want=0", bus.stm_valid); end
        @(negedge clk);
        checks++; if (bus.stm_valid !== 1'b1) begin failures++; $display("FAIL lat_valid_2edge got=%b want=1", bus.stm_valid); end
        handshake(d, seen, fe);
        checks++; if (exp_q.size() == 0 || d !== exp_q[0]) begin failures++; $display("FAIL lat_data got=%h want=%h", d, (exp_q.size() != 0) ? exp_q[0] : 'x); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        checks++; if (fe != 3) begin failures++; $display("FAIL lat_ack_fall got=%0d want=3", fe); end
        repeat (4) @(negedge clk);
        checks++; if (read_cnt - r0 != 1) begin failures++; $display("FAIL lat_pulses got=%0d want=1", read_cnt - r0); end
    endtask

    task automatic test_mono();
        logic [AW-1:0] vl[11], vr[11], want, d;
        logic [AW-1:0] spec_w[3];
        bit got, seen;
        int fe;
        vl[0] = 16'h8000; vr[0] = 16'h7FFE; spec_w[0] = 16'hFFFF;
        vl[1] = 16'h7FFF; vr[1] = 16'h7FFF; spec_w[1] = 16'h7FFF;
        vl[2] = 16'h0003; vr[2] = 16'h0000; spec_w[2] = 16'h0001;
        for (int i = 3; i < 11; i++) begin
            vl[i] = AW'($urandom);
            vr[i] = AW'($urandom);
        end
        for (int i = 0; i < 11; i++) begin
            send_sample(vl[i], vr[i], got);
            handshake(d, seen, fe);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (!seen || d !== want) begin failures++; $display("FAIL mono_%0d got=%h want=%h", i, d, want); end
`ifndef STM_TX_TESTPAT_EN
            if (i < 3) begin
                checks++; if (d !== spec_w[i]) begin failures++; $display("FAIL mono_fixed_%0d got=%h want=%h", i, d, spec_w[i]); end
            end
`endif
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_overflow();
        bit got, seen;
        int r0, fe;
        logic [AW-1:0] d, want;
        r0 = read_cnt;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b want=0", overflow); end
        for (int i = 0; i < 10; i++) send_sample(AW'($urandom), AW'($urandom), got);
        repeat (4) @(negedge clk);
        checks++; if (read_cnt - r0 != 10) begin failures++; $display("FAIL ovf_pulses got=%0d want=10", read_cnt - r0); end
        checks++; if (fifo_level !== 8) begin failures++; $display("FAIL ovf_level got=%0d want=8", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", overflow); end
        checks++; if (exp_q.size() != 9) begin failures++; $display("FAIL ovf_model got=%0d want=9", exp_q.size()); end
        checks++; if (bus.stm_valid !== 1'b1 || bus.stm_data !== exp_q[0]) begin failures++; $display("FAIL ovf_head got=%b/%h want=1/%h", bus.stm_valid, bus.stm_data, exp_q[0]); end
        for (int i = 0; i < 9; i++) begin
            handshake(d, seen, fe);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (!seen || d !== want) begin failures++; $display("FAIL ovf_drain_%0d got=%h want=%h", i, d, want); end
        end
        repeat (6) @(negedge clk);
        checks++; if (fifo_level !== 0 || bus.stm_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%0d/%b want=0/0", fifo_level, bus.stm_valid); end
        checks++; if (dbl_read != 0) begin failures++; $display("FAIL read_twice got=%0d want=0", dbl_read); end
    endtask

    task automatic test_timeout();
        bit got;
        int n, hi;
        logic [AW-1:0] want;
        bus.stm_ack = 1'b0;
        checks++; if (ack_timeout !== 1'b0) begin failures++; $display("FAIL to_pre got=%b want=0", ack_timeout); end
        send_sample(AW'($urandom), AW'($urandom), got);
        send_sample(AW'($urandom), AW'($urandom), got);
        wait_valid(1'b1, 20, n);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.stm_valid !== 1'b1 || bus.stm_data !== want) begin failures++; $display("FAIL to_word1 got=%b/%h want=1/%h", bus.stm_valid, bus.stm_data, want); end
        hi = 0;
        while (bus.stm_valid === 1'b1 && hi < 300) begin
            @(negedge clk);
            hi++;
        end
        checks++; if (hi != TMO) begin failures++; $display("FAIL to_high_cycles got=%0d want=%0d", hi, TMO); end
        checks++; if (ack_timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b want=1", ack_timeout); end
        wait_valid(1'b1, 4, n);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (bus.stm_valid !== 1'b1 || bus.stm_data !== want) begin failures++; $display("FAIL to_word2 got=%b/%h after %0d want=1/%h", bus.stm_valid, bus.stm_data, n, want); end
        wait_valid(1'b0, TMO + 20, n);
        checks++; if (bus.stm_valid !== 1'b0) begin failures++; $display("FAIL to_word2_drop got=%b want=0", bus.stm_valid); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got, seen;
        int fe;
        logic [AW-1:0] d, want;
        bus.stm_ack = 1'b0;
        for (int i = 0; i < 4; i++) send_sample(AW'($urandom), AW'($urandom), got);
        repeat (4) @(negedge clk);
        checks++; if (bus.stm_valid !== 1'b1 || fifo_level !== 3) begin failures++; $display("FAIL rst_mid_pre got=%b/%0d want=1/3", bus.stm_valid, fifo_level); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.stm_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", bus.stm_valid); end
        checks++; if (fifo_level !== 0) begin failures++; $display("FAIL rst_mid_level got=%0d want=0", fifo_level); end
        checks++; if (overflow !== 1'b0 || ack_timeout !== 1'b0) begin failures++; $display("FAIL rst_mid_flags got=%b/%b want=0/0", overflow, ack_timeout); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        send_sample(AW'($urandom), AW'($urandom), got);
        handshake(d, seen, fe);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        checks++; if (!seen || d !== want) begin failures++; $display("FAIL rst_resume got=%h want=%h", d, want); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen;
        int r0, fe;
        logic [AW-1:0] l, r, d, want;
        l = AW'($urandom);
        r = AW'($urandom);
        r0 = read_cnt;
        bus.left_channel_audio_in  = l;
        bus.right_channel_audio_in = r;
        bus.audio_in_available     = 1'b1;
        repeat (10) @(negedge clk);
        bus.audio_in_available = 1'b0;
        for (int i = 0; i < 5; i++) model_capture(l, r);
        checks++; if (read_cnt - r0 != 5) begin failures++; $display("FAIL b2b_pulses got=%0d want=5", read_cnt - r0); end
        checks++; if (dbl_read != 0) begin failures++; $display("FAIL b2b_read_twice got=%0d want=0", dbl_read); end
        for (int i = 0; i < 5; i++) begin
            handshake(d, seen, fe);
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            checks++; if (!seen || d !== want) begin failures++; $display("FAIL b2b_word_%0d got=%h want=%h", i, d, want); end
        end
        repeat (4) @(negedge clk);
    endtask

`ifdef STM_TX_TESTPAT_EN
    task automatic test_testpat();
        bit got, seen;
        int fe;
        logic [AW-1:0] d;
        test_reset();
        for (int i = 0; i < 5; i++) begin
            send_sample(AW'($urandom), AW'($urandom), got);
            handshake(d, seen, fe);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            checks++; if (!seen || d !== AW'(i)) begin failures++; $display("FAIL testpat_%0d got=%h want=%h", i, d, AW'(i)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_mono();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
`ifdef STM_TX_TESTPAT_EN
        test_testpat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
